// File: rtl/pipe_ctrl.sv
// pipe_ctrl: decode, conditional execution and hazard control for a 5-stage ARM pipeline.
// Latency: decode is combinational in D; E controls +1 cycle, MemWriteM +2, W controls +3.
// Backpressure: a load-use hazard stalls F/D and bubbles E; a pending PC write stalls F and flushes D.
// Ports: clk/reset (sync, active-low); Cond/Op/Funct/Rd are the D-stage instruction fields;
//   N_in..V_in are the E-stage ALU flags; RA*/WA3* are register addresses exported by the datapath;
//   outputs are stage-suffixed controls, stall/flush strobes and forwarding selects.
module pipe_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       N_in,
  input  logic       Z_in,
  input  logic       C_in,
  input  logic       V_in,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  output logic [1:0] ImmSrcD,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControlE,
  output logic [1:0] ALUSrcE,
  output logic       shifter_control,
  output logic       BranchTakenE,
  output logic       MemWriteM,
  output logic       RegWriteW,
  output logic       MemtoRegW,
  output logic       PCSrcW,
  output logic       RegSrcZeroW,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  // ---------------- Decode (D) ----------------
  logic       reg_write_d, mem_to_reg_d, mem_write_d, branch_d, bl_d, flag_write_d, shifter_d, pcs_d;
  logic [3:0] alu_control_d;
  logic [1:0] alu_src_d;

  // While reset is held the decoded instruction is forced to a NOP, so the
  // combinational D-stage outputs and PC-write hazard are quiet as well.
  always_comb begin
    reg_write_d   = 1'b0;
    mem_to_reg_d  = 1'b0;
    mem_write_d   = 1'b0;
    branch_d      = 1'b0;
    bl_d          = 1'b0;
    flag_write_d  = 1'b0;
    shifter_d     = 1'b0;
    alu_control_d = 4'b0000;
    alu_src_d     = 2'b00;
    ImmSrcD       = 2'b00;
    RegSrc        = 2'b00;
    if (reset) begin
      case (Op)
        2'b00: begin
          alu_control_d = Funct[4:1];
          alu_src_d     = 2'b10;
          shifter_d     = Funct[5];
          // cmd 10xx are the compare/test ops: flags only, no register write
          reg_write_d   = (Funct[4:3] != 2'b10);
          flag_write_d  = Funct[0] | (Funct[4:3] == 2'b10);
        end
        2'b01: begin
          alu_control_d = 4'b0100;
          alu_src_d     = 2'b01;
          ImmSrcD       = 2'b01;
          RegSrc        = {~Funct[0], 1'b0};
          reg_write_d   = Funct[0];
          mem_to_reg_d  = Funct[0];
          mem_write_d   = ~Funct[0];
        end
        2'b10: begin
          alu_control_d = 4'b0100;
          alu_src_d     = 2'b01;
          ImmSrcD       = 2'b10;
          RegSrc        = 2'b01;
          branch_d      = 1'b1;
          reg_write_d   = Funct[4];
          bl_d          = Funct[4];
        end
        default: begin
          alu_control_d = 4'b0000;
        end
      endcase
    end
  end

  assign pcs_d = (Rd == 4'hF) & reg_write_d & ~bl_d;

  // ---------------- D -> E ----------------
  logic       reg_write_e, mem_to_reg_e, mem_write_e, branch_e, bl_e, pcs_e, flag_write_e, shifter_e;
  logic [3:0] alu_control_e, cond_e;
  logic [1:0] alu_src_e;

  always_ff @(posedge clk) begin
    if (!reset || FlushE) begin
      reg_write_e   <= 1'b0;
      mem_to_reg_e  <= 1'b0;
      mem_write_e   <= 1'b0;
      branch_e      <= 1'b0;
      bl_e          <= 1'b0;
      pcs_e         <= 1'b0;
      flag_write_e  <= 1'b0;
      shifter_e     <= 1'b0;
      alu_control_e <= 4'b0000;
      alu_src_e     <= 2'b00;
      cond_e        <= 4'b0000;
    end else begin
      reg_write_e   <= reg_write_d;
      mem_to_reg_e  <= mem_to_reg_d;
      mem_write_e   <= mem_write_d;
      branch_e      <= branch_d;
      bl_e          <= bl_d;
      pcs_e         <= pcs_d;
      flag_write_e  <= flag_write_d;
      shifter_e     <= shifter_d;
      alu_control_e <= alu_control_d;
      alu_src_e     <= alu_src_d;
      cond_e        <= Cond;
    end
  end

  // ---------------- Condition check (E) ----------------
  logic [3:0] flags;
  logic       flag_n, flag_z, flag_c, flag_v, cond_ex_e;
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  always_comb begin
    cond_ex_e = 1'b0;
    case (cond_e)
      4'b0000: cond_ex_e = flag_z;
      4'b0001: cond_ex_e = ~flag_z;
      4'b0010: cond_ex_e = flag_c;
      4'b0011: cond_ex_e = ~flag_c;
      4'b0100: cond_ex_e = flag_n;
      4'b0101: cond_ex_e = ~flag_n;
      4'b0110: cond_ex_e = flag_v;
      4'b0111: cond_ex_e = ~flag_v;
      4'b1000: cond_ex_e = flag_c & ~flag_z;
      4'b1001: cond_ex_e = ~(flag_c & ~flag_z);
      4'b1010: cond_ex_e = (flag_n == flag_v);
      4'b1011: cond_ex_e = (flag_n != flag_v);
      4'b1100: cond_ex_e = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex_e = ~(~flag_z & (flag_n == flag_v));
      4'b1110: cond_ex_e = 1'b1;
      default: cond_ex_e = 1'b0;
    endcase
  end

  // Written at the end of the setter's E cycle so the next instruction sees it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else if (flag_write_e && cond_ex_e) begin
      flags <= {N_in, Z_in, C_in, V_in};
    end
  end

  // ---------------- E -> M -> W ----------------
  logic reg_write_m, mem_to_reg_m, mem_write_m, pcs_m, bl_m;
  logic reg_write_w, mem_to_reg_w, pcs_w, bl_w;

  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      mem_write_m  <= 1'b0;
      pcs_m        <= 1'b0;
      bl_m         <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      pcs_w        <= 1'b0;
      bl_w         <= 1'b0;
    end else begin
      reg_write_m  <= reg_write_e & cond_ex_e;
      mem_to_reg_m <= mem_to_reg_e;
      mem_write_m  <= mem_write_e & cond_ex_e;
      pcs_m        <= pcs_e & cond_ex_e;
      bl_m         <= bl_e & cond_ex_e;
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      pcs_w        <= pcs_m;
      bl_w         <= bl_m;
    end
  end

  // ---------------- Outputs and hazards ----------------
  logic ldr_stall, pc_wr_pend;

  assign ALUControlE     = alu_control_e;
  assign ALUSrcE         = alu_src_e;
  assign shifter_control = shifter_e;
  assign BranchTakenE    = branch_e & cond_ex_e;
  assign MemWriteM       = mem_write_m;
  assign RegWriteW       = reg_write_w;
  assign MemtoRegW       = mem_to_reg_w;
  assign PCSrcW          = pcs_w;
  assign RegSrcZeroW     = bl_w;

  // M has priority over W: it holds the younger write to the same register.
  assign ForwardAE = (reg_write_m && (RA1E == WA3M)) ? 2'b10 :
                     (reg_write_w && (RA1E == WA3W)) ? 2'b01 : 2'b00;
  assign ForwardBE = (reg_write_m && (RA2E == WA3M)) ? 2'b10 :
                     (reg_write_w && (RA2E == WA3W)) ? 2'b01 : 2'b00;

  assign ldr_stall  = mem_to_reg_e & reg_write_e & ((RA1D == WA3E) | (RA2D == WA3E));
  // E uses the ungated PCS: the condition outcome is not known early enough to release fetch.
  assign pc_wr_pend = pcs_d | pcs_e | pcs_m;

  assign StallF = ldr_stall | pc_wr_pend;
  assign StallD = ldr_stall;
  assign FlushD = pc_wr_pend | pcs_w | BranchTakenE;
  assign FlushE = ldr_stall | BranchTakenE;

endmodule

// File: tb/tb_pipe_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] Cond, Rd;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       N_in, Z_in, C_in, V_in;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic [1:0] ImmSrcD, RegSrc, ALUSrcE, ForwardAE, ForwardBE;
  logic [3:0] ALUControlE;
  logic       shifter_control, BranchTakenE, MemWriteM, RegWriteW, MemtoRegW, PCSrcW, RegSrcZeroW;
  logic       StallF, StallD, FlushD, FlushE;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .N_in(N_in), .Z_in(Z_in), .C_in(C_in), .V_in(V_in),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .ImmSrcD(ImmSrcD), .RegSrc(RegSrc), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .shifter_control(shifter_control), .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .RegSrcZeroW(RegSrcZeroW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  typedef struct packed {
    logic [1:0] imm_src; logic [1:0] reg_src; logic [3:0] alu_ctl; logic [1:0] alu_src; logic shift;
    logic btk; logic mw_m; logic rw_w; logic mtr_w; logic pcs_w; logic bl_w;
    logic stall_f; logic stall_d; logic flush_d; logic flush_e; logic [1:0] fwd_a; logic [1:0] fwd_b;
  } obs_t;

  obs_t dut_o;
  assign dut_o = {ImmSrcD, RegSrc, ALUControlE, ALUSrcE, shifter_control, BranchTakenE, MemWriteM,
                  RegWriteW, MemtoRegW, PCSrcW, RegSrcZeroW, StallF, StallD, FlushD, FlushE,
                  ForwardAE, ForwardBE};

  // ---------------- reference model: one record per pipeline slot ----------------
  typedef struct packed {
    logic rw, mtr, mw, br, bl, pcs, fw;
    logic [3:0] alu; logic [1:0] src; logic sh; logic [3:0] cond; logic [1:0] imm, rsrc;
  } ctl_t;
  typedef struct packed { logic rw, mtr, mw, pcs, bl; } late_t;

  ctl_t       m_d, m_e;
  late_t      m_late [2];  // [0] = M slot, [1] = W slot
  logic [3:0] m_flags;     // {N,Z,C,V}
  logic       exp_pass;
  obs_t       exp_o;
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic ctl_t decode_instr(input logic [1:0] op, input logic [5:0] fn,
                                        input logic [3:0] rd, input logic [3:0] cond);
    ctl_t c;
    logic [3:0] cmd;
    c = '0;
    cmd = fn[4:1];
    c.cond = cond;
    case (op)
      2'b00: begin
        c.alu = cmd; c.src = 2'b10; c.sh = fn[5];
        c.rw = (cmd[3:2] != 2'b10); c.fw = fn[0] || (cmd[3:2] == 2'b10);
      end
      2'b01: begin
        c.alu = 4'b0100; c.src = 2'b01; c.imm = 2'b01; c.rsrc = {~fn[0], 1'b0};
        c.rw = fn[0]; c.mtr = fn[0]; c.mw = ~fn[0];
      end
      2'b10: begin
        c.alu = 4'b0100; c.src = 2'b01; c.imm = 2'b10; c.rsrc = 2'b01;
        c.br = 1'b1; c.rw = fn[4]; c.bl = fn[4];
      end
      default: c.cond = cond;
    endcase
    c.pcs = (rd == 4'hF) && c.rw && !c.bl;
    return c;
  endfunction

  function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;                 // EQ
      4'h1: return !z;                // NE
      4'h2: return c;                 // CS
      4'h3: return !c;                // CC
      4'h4: return n;                 // MI
      4'h5: return !n;                // PL
      4'h6: return v;                 // VS
      4'h7: return !v;                // VC
      4'h8: return c && !z;           // HI
      4'h9: return !c || z;           // LS
      4'hA: return n == v;            // GE
      4'hB: return n != v;            // LT
      4'hC: return !z && (n == v);    // GT
      4'hD: return z || (n != v);     // LE
      4'hE: return 1'b1;              // AL
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
    if (m_late[0].rw && ra == WA3M) return 2'b10;
    if (m_late[1].rw && ra == WA3W) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    logic ldr, pend;
    m_d = reset ? decode_instr(Op, Funct, Rd, Cond) : '0;
    exp_pass = cond_holds(m_e.cond, m_flags);
    exp_o = '0;
    exp_o.imm_src = m_d.imm;
    exp_o.reg_src = m_d.rsrc;
    exp_o.alu_ctl = m_e.alu;
    exp_o.alu_src = m_e.src;
    exp_o.shift   = m_e.sh;
    exp_o.btk     = m_e.br && exp_pass;
    exp_o.mw_m    = m_late[0].mw;
    exp_o.rw_w    = m_late[1].rw;
    exp_o.mtr_w   = m_late[1].mtr;
    exp_o.pcs_w   = m_late[1].pcs;
    exp_o.bl_w    = m_late[1].bl;
    exp_o.fwd_a   = fwd_sel(RA1E);
    exp_o.fwd_b   = fwd_sel(RA2E);
    ldr  = m_e.mtr && m_e.rw && (RA1D == WA3E || RA2D == WA3E);
    pend = m_d.pcs || m_e.pcs || m_late[0].pcs;
    exp_o.stall_f = ldr || pend;
    exp_o.stall_d = ldr;
    exp_o.flush_d = pend || m_late[1].pcs || exp_o.btk;
    exp_o.flush_e = ldr || exp_o.btk;
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_e = '0; m_late[0] = '0; m_late[1] = '0; m_flags = '0;
    end else begin
      if (m_e.fw && exp_pass) m_flags = {N_in, Z_in, C_in, V_in};
      m_late[1]     = m_late[0];
      m_late[0].rw  = m_e.rw && exp_pass;
      m_late[0].mtr = m_e.mtr;
      m_late[0].mw  = m_e.mw && exp_pass;
      m_late[0].pcs = m_e.pcs && exp_pass;
      m_late[0].bl  = m_e.bl && exp_pass;
      m_e = exp_o.flush_e ? '0 : m_d;
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    model_eval();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- small program runner ----------------
  typedef struct packed {
    logic [3:0] cond; logic [1:0] op; logic [5:0] fn;
    logic [3:0] rd, ra1, ra2, wa3, nzcv;
  } ins_t;

  ins_t prog[$];
  obs_t tr_dut[$];
  obs_t tr_exp[$];

  function automatic ins_t mk(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] fn,
                              input logic [3:0] rd, input logic [3:0] ra1, input logic [3:0] ra2,
                              input logic [3:0] wa3, input logic [3:0] nzcv);
    ins_t r;
    r.cond = cond; r.op = op; r.fn = fn; r.rd = rd;
    r.ra1 = ra1; r.ra2 = ra2; r.wa3 = wa3; r.nzcv = nzcv;
    return r;
  endfunction

  ins_t nop_i;

  task automatic do_reset();
    reset = 1'b0;
    {Cond, Op, Funct, Rd} = {4'hE, 2'b11, 6'h0, 4'h0};
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {N_in, Z_in, C_in, V_in} = 4'b0000;
    to_neg();
    to_pos();
    reset = 1'b1;
  endtask

  // Fetch resumes with the next program entry after a flush; wrong-path
  // instructions are placed in the program explicitly.
  task automatic run_prog(input int ncyc);
    ins_t d_i, e_i, m_i, w_i;
    int ptr;
    d_i = (prog.size() > 0) ? prog[0] : nop_i;
    ptr = 1; e_i = nop_i; m_i = nop_i; w_i = nop_i;
    tr_dut.delete(); tr_exp.delete();
    for (int c = 0; c < ncyc; c++) begin
      {Cond, Op, Funct, Rd} = {d_i.cond, d_i.op, d_i.fn, d_i.rd};
      RA1D = d_i.ra1; RA2D = d_i.ra2;
      RA1E = e_i.ra1; RA2E = e_i.ra2; WA3E = e_i.wa3;
      WA3M = m_i.wa3; WA3W = w_i.wa3;
      {N_in, Z_in, C_in, V_in} = e_i.nzcv;
      to_neg();
      tr_dut.push_back(dut_o);
      tr_exp.push_back(exp_o);
      to_pos();
      w_i = m_i; m_i = e_i;
      e_i = exp_o.flush_e ? nop_i : d_i;
      if (exp_o.flush_d) d_i = nop_i;
      else if (!exp_o.stall_d) begin
        d_i = (ptr < prog.size()) ? prog[ptr] : nop_i;
        ptr++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    to_pos();
    for (int i = 0; i < 2; i++) begin
      {Cond, Op, Funct, Rd} = 16'($urandom);
      {RA1D, RA2D, RA1E, RA2E} = 16'($urandom);
      {WA3E, WA3M, WA3W} = 12'($urandom);
      {N_in, Z_in, C_in, V_in} = 4'($urandom);
      to_neg();
      n_tests++;
      if (dut_o !== obs_t'(0)) begin
        n_fail++;
        $display("FAIL reset cycle %0d: outputs %h, required all zero", i, dut_o);
      end
      to_pos();
    end
    reset = 1'b1;
  endtask

  task automatic test_forward();
    do_reset();
    prog = '{mk(4'hE, 2'b00, 6'b001000, 4'd1, 4'd2, 4'd3, 4'd1, 4'h0),
             mk(4'hE, 2'b00, 6'b000100, 4'd4, 4'd1, 4'd5, 4'd4, 4'h0)};
    run_prog(5);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (tr_dut[i] !== tr_exp[i]) begin
        n_fail++; $display("FAIL fwd_m model cycle %0d: got %h expected %h", i, tr_dut[i], tr_exp[i]);
      end
    end
    n_tests++;
    if (tr_dut[2].fwd_a !== 2'b10 || tr_dut[2].fwd_b !== 2'b00) begin
      n_fail++; $display("FAIL fwd_from_m: got A=%b B=%b, required A=10 B=00", tr_dut[2].fwd_a, tr_dut[2].fwd_b);
    end
    n_tests++;
    if (tr_dut[1].alu_ctl !== 4'b0100 || tr_dut[2].alu_ctl !== 4'b0010 || tr_dut[1].alu_src !== 2'b10) begin
      n_fail++; $display("FAIL alu_ctl_latency: got %b/%b src %b, required 0100/0010 src 10",
                         tr_dut[1].alu_ctl, tr_dut[2].alu_ctl, tr_dut[1].alu_src);
    end
    do_reset();
    prog = '{mk(4'hE, 2'b00, 6'b001000, 4'd1, 4'd2, 4'd3, 4'd1, 4'h0), nop_i,
             mk(4'hE, 2'b00, 6'b000100, 4'd4, 4'd1, 4'd5, 4'd4, 4'h0)};
    run_prog(6);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (tr_dut[i] !== tr_exp[i]) begin
        n_fail++; $display("FAIL fwd_w model cycle %0d: got %h expected %h", i, tr_dut[i], tr_exp[i]);
      end
    end
    n_tests++;
    if (tr_dut[3].fwd_a !== 2'b01) begin
      n_fail++; $display("FAIL fwd_from_w: got %b, required 01", tr_dut[3].fwd_a);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    prog = '{mk(4'hE, 2'b01, 6'b011001, 4'd1, 4'd0, 4'd0, 4'd1, 4'h0),
             mk(4'hE, 2'b00, 6'b001000, 4'd2, 4'd1, 4'd1, 4'd2, 4'h0)};
    run_prog(6);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (tr_dut[i] !== tr_exp[i]) begin
        n_fail++; $display("FAIL ldr model cycle %0d: got %h expected %h", i, tr_dut[i], tr_exp[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({tr_dut[i].stall_f, tr_dut[i].stall_d, tr_dut[i].flush_e} !== {3{i == 1}}) begin
        n_fail++; $display("FAIL ldr_stall cycle %0d: got F/D/E=%b%b%b, required %0d%0d%0d", i,
                           tr_dut[i].stall_f, tr_dut[i].stall_d, tr_dut[i].flush_e, i == 1, i == 1, i == 1);
      end
    end
    n_tests++;
    if (tr_dut[3].fwd_a !== 2'b01 || tr_dut[3].fwd_b !== 2'b01) begin
      n_fail++; $display("FAIL ldr_fwd: got A=%b B=%b, required 01 01", tr_dut[3].fwd_a, tr_dut[3].fwd_b);
    end
    n_tests++;
    if (tr_dut[3].rw_w !== 1'b1 || tr_dut[3].mtr_w !== 1'b1 || tr_dut[0].imm_src !== 2'b01) begin
      n_fail++; $display("FAIL ldr_wb: got rw=%b mtr=%b imm=%b, required 1 1 01",
                         tr_dut[3].rw_w, tr_dut[3].mtr_w, tr_dut[0].imm_src);
    end
  endtask

  task automatic test_cond();
    do_reset();
    prog = '{mk(4'hE, 2'b00, 6'b010101, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0100),   // CMP R0,R0
             mk(4'h1, 2'b00, 6'b001000, 4'd1, 4'd2, 4'd3, 4'd1, 4'h0),      // ADDNE
             mk(4'h1, 2'b01, 6'b011000, 4'd4, 4'd0, 4'd4, 4'd4, 4'h0),      // STRNE
             mk(4'h0, 2'b00, 6'b001000, 4'd5, 4'd2, 4'd3, 4'd5, 4'h0),      // ADDEQ
             mk(4'h0, 2'b01, 6'b011000, 4'd6, 4'd0, 4'd6, 4'd6, 4'h0)};     // STREQ
    run_prog(9);
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (tr_dut[i] !== tr_exp[i]) begin
        n_fail++; $display("FAIL cond model cycle %0d: got %h expected %h", i, tr_dut[i], tr_exp[i]);
      end
    end
    n_tests++;
    if (tr_dut[4].rw_w !== 1'b0 || tr_dut[4].mw_m !== 1'b0 || tr_dut[5].rw_w !== 1'b0) begin
      n_fail++; $display("FAIL cond_ne_gated: got rw_w=%b mw_m=%b, required 0 0", tr_dut[4].rw_w, tr_dut[4].mw_m);
    end
    n_tests++;
    if (tr_dut[6].rw_w !== 1'b1 || tr_dut[6].mw_m !== 1'b1) begin
      n_fail++; $display("FAIL cond_eq_pass: got rw_w=%b mw_m=%b, required 1 1", tr_dut[6].rw_w, tr_dut[6].mw_m);
    end
  endtask

  task automatic test_branch();
    do_reset();
    prog = '{mk(4'hE, 2'b10, 6'b100000, 4'd0, 4'd0, 4'd0, 4'd0, 4'h0),      // B
             mk(4'hE, 2'b00, 6'b001000, 4'd7, 4'd0, 4'd0, 4'd7, 4'h0),      // wrong path
             mk(4'hE, 2'b00, 6'b010101, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0100),   // CMP, Z=1
             mk(4'h1, 2'b10, 6'b100000, 4'd0, 4'd0, 4'd0, 4'd0, 4'h0),      // BNE
             mk(4'hE, 2'b00, 6'b001000, 4'd8, 4'd0, 4'd0, 4'd8, 4'h0),
             mk(4'hE, 2'b10, 6'b110000, 4'd0, 4'd0, 4'd0, 4'd14, 4'h0)};    // BL
    run_prog(11);
    for (int i = 0; i < 11; i++) begin
      n_tests++;
      if (tr_dut[i] !== tr_exp[i]) begin
        n_fail++; $display("FAIL br model cycle %0d: got %h expected %h", i, tr_dut[i], tr_exp[i]);
      end
    end
    n_tests++;
    if ({tr_dut[1].btk, tr_dut[1].flush_d, tr_dut[1].flush_e} !== 3'b111 ||
        {tr_dut[2].btk, tr_dut[2].flush_d, tr_dut[2].flush_e} !== 3'b000) begin
      n_fail++; $display("FAIL br_taken: got %b then %b, required 111 then 000",
                         {tr_dut[1].btk, tr_dut[1].flush_d, tr_dut[1].flush_e},
                         {tr_dut[2].btk, tr_dut[2].flush_d, tr_dut[2].flush_e});
    end
    n_tests++;
    if (tr_dut[5].btk !== 1'b0 || tr_dut[5].flush_d !== 1'b0) begin
      n_fail++; $display("FAIL bne_not_taken: got btk=%b flush_d=%b, required 0 0", tr_dut[5].btk, tr_dut[5].flush_d);
    end
    n_tests++;
    if (tr_dut[7].btk !== 1'b1 || tr_dut[9].bl_w !== 1'b1 || tr_dut[9].rw_w !== 1'b1 || tr_dut[0].imm_src !== 2'b10) begin
      n_fail++; $display("FAIL bl_link: got btk=%b bl_w=%b rw_w=%b imm=%b, required 1 1 1 10",
                         tr_dut[7].btk, tr_dut[9].bl_w, tr_dut[9].rw_w, tr_dut[0].imm_src);
    end
  endtask

  task automatic test_pc_write();
    do_reset();
    prog = '{mk(4'hE, 2'b00, 6'b011010, 4'hF, 4'd0, 4'd3, 4'd15, 4'h0),     // MOV PC,R3
             mk(4'hE, 2'b00, 6'b001000, 4'd1, 4'd2, 4'd3, 4'd1, 4'h0)};
    run_prog(7);
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (tr_dut[i] !== tr_exp[i]) begin
        n_fail++; $display("FAIL pcw model cycle %0d: got %h expected %h", i, tr_dut[i], tr_exp[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (tr_dut[i].stall_f !== (i <= 2) || tr_dut[i].flush_d !== (i <= 3) || tr_dut[i].pcs_w !== (i == 3)) begin
        n_fail++; $display("FAIL pc_write cycle %0d: got stallF=%b flushD=%b pcsrcW=%b, required %0d %0d %0d", i,
                           tr_dut[i].stall_f, tr_dut[i].flush_d, tr_dut[i].pcs_w, i <= 2, i <= 3, i == 3);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 15) != 0);
      Cond  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      Op    = 2'($urandom_range(0, 3));
      Funct = 6'($urandom_range(0, 63));
      Rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3)); WA3W = 4'($urandom_range(0, 3));
      {N_in, Z_in, C_in, V_in} = 4'($urandom_range(0, 15));
      to_neg();
      n_tests++;
      if (dut_o !== exp_o) begin
        n_fail++; $display("FAIL random cycle %0d: got %h expected %h", i, dut_o, exp_o);
      end
      to_pos();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nop_i = mk(4'hE, 2'b11, 6'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    m_e = '0; m_late[0] = '0; m_late[1] = '0; m_flags = '0; m_d = '0; exp_o = '0; exp_pass = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_cond();
    test_branch();
    test_pc_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
